// File: rtl/ppg_ratio_if.sv
// ppg_ratio_if: groups the LED/ADC capture inputs and the ratio-engine results.
//   track_en, led_red, led_ir, red_adc, ir_adc : controller side -> engine
//   red_ac, red_dc, ir_ac, ir_dc               : last accepted window statistics
//   ratio, ratio_valid, ratio_err              : ratio-of-ratios result and strobe
//   overrun, busy                              : status
// master = the controller/test side, slave = the ratio engine.
interface ppg_ratio_if #(
    parameter int unsigned RATIO_W = 10
);
    logic               track_en;
    logic               led_red;
    logic               led_ir;
    logic [7:0]         red_adc;
    logic [7:0]         ir_adc;
    logic [7:0]         red_ac;
    logic [7:0]         red_dc;
    logic [7:0]         ir_ac;
    logic [7:0]         ir_dc;
    logic [RATIO_W-1:0] ratio;
    logic               ratio_valid;
    logic               ratio_err;
    logic               overrun;
    logic               busy;

    modport master (
        output track_en, led_red, led_ir, red_adc, ir_adc,
        input  red_ac, red_dc, ir_ac, ir_dc, ratio, ratio_valid, ratio_err, overrun, busy
    );

    modport slave (
        input  track_en, led_red, led_ir, red_adc, ir_adc,
        output red_ac, red_dc, ir_ac, ir_dc, ratio, ratio_valid, ratio_err, overrun, busy
    );
endinterface

// File: rtl/ppg_ratio_engine.sv
// ppg_ratio_engine: windowed peak/trough/mean tracking of the RED and IR PPG samples and a
// sequential restoring divider producing R = (AC_red*DC_ir)/(AC_ir*DC_red) in fixed point.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : ppg_ratio_if.slave (LED/ADC inputs, window statistics, ratio, status)
module ppg_ratio_engine #(
    parameter int unsigned WIN_LOG2 = 5,
    parameter int unsigned FRAC     = 7,
    parameter int unsigned RATIO_W  = 10
) (
    input logic         clk,
    input logic         rst,
    ppg_ratio_if.slave  bus
);
    localparam int unsigned CW  = WIN_LOG2 + 1;
    localparam int unsigned SW  = 8 + WIN_LOG2;
    localparam int unsigned NW  = 16 + FRAC;
    localparam int unsigned STW = $clog2(NW);
    localparam logic [CW-1:0]  FULL = {1'b1, {WIN_LOG2{1'b0}}};
    localparam logic [STW-1:0] LAST = STW'(NW - 1);

    typedef enum logic [1:0] {StIdle, StMult, StDiv, StDone} state_e;

    // Channel index 0 = RED, 1 = IR.
    logic          led_red_q, led_ir_q;
    logic [1:0]    fall;
    logic [7:0]    sample [2];
    logic [CW-1:0] cnt_q [2], cnt_d [2];
    logic [7:0]    max_q [2], max_d [2];
    logic [7:0]    min_q [2], min_d [2];
    logic [SW-1:0] sum_q [2], sum_d [2];
    logic          close;

    state_e             state_q, state_d;
    logic [NW-1:0]      num_q, num_d, num_next;
    logic [15:0]        den_q, den_d;
    logic [15:0]        rem_q, rem_d, rem_diff;
    logic [16:0]        rem_sh;
    logic               q_bit;
    logic [STW-1:0]     step_q, step_d;
    logic [15:0]        prod_n, prod_d;
    logic [7:0]         red_ac_q, red_ac_d, red_dc_q, red_dc_d;
    logic [7:0]         ir_ac_q, ir_ac_d, ir_dc_q, ir_dc_d;
    logic [RATIO_W-1:0] ratio_q, ratio_d;
    logic               err_q, err_d, valid_q, valid_d, overrun_q, overrun_d;

    assign fall[0]   = bus.track_en & led_red_q & ~bus.led_red;
    assign fall[1]   = bus.track_en & led_ir_q & ~bus.led_ir;
    assign sample[0] = bus.red_adc;
    assign sample[1] = bus.ir_adc;
    assign close     = bus.track_en & (cnt_q[0] == FULL) & (cnt_q[1] == FULL);

    // Accumulators: a closing window or an empty channel makes the next capture sample 1.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            cnt_d[c] = cnt_q[c];
            max_d[c] = max_q[c];
            min_d[c] = min_q[c];
            sum_d[c] = sum_q[c];
            if (!bus.track_en) begin
                cnt_d[c] = '0;
                max_d[c] = '0;
                min_d[c] = '0;
                sum_d[c] = '0;
            end else if (close || cnt_q[c] == '0) begin
                if (fall[c]) begin
                    cnt_d[c] = CW'(1);
                    max_d[c] = sample[c];
                    min_d[c] = sample[c];
                    sum_d[c] = SW'(sample[c]);
                end else if (close) begin
                    cnt_d[c] = '0;
                    max_d[c] = '0;
                    min_d[c] = '0;
                    sum_d[c] = '0;
                end
            end else if (fall[c] && cnt_q[c] != FULL) begin
                cnt_d[c] = cnt_q[c] + 1'b1;
                sum_d[c] = sum_q[c] + SW'(sample[c]);
                if (sample[c] > max_q[c]) max_d[c] = sample[c];
                if (sample[c] < min_q[c]) min_d[c] = sample[c];
            end
        end
    end

    assign prod_n = 16'(red_ac_q) * 16'(ir_dc_q);
    assign prod_d = 16'(ir_ac_q) * 16'(red_dc_q);

    // One restoring step: remainder stays below den, so the low 16 bits of the difference are
    // exact whenever the subtraction is taken.
    assign rem_sh   = {rem_q, num_q[NW-1]};
    assign q_bit    = (rem_sh >= {1'b0, den_q});
    assign rem_diff = rem_sh[15:0] - den_q;
    assign num_next = {num_q[NW-2:0], q_bit};

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        den_d     = den_q;
        rem_d     = rem_q;
        step_d    = step_q;
        red_ac_d  = red_ac_q;
        red_dc_d  = red_dc_q;
        ir_ac_d   = ir_ac_q;
        ir_dc_d   = ir_dc_q;
        ratio_d   = ratio_q;
        err_d     = err_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        if (!bus.track_en) begin
            state_d   = StIdle;
            overrun_d = 1'b0;
        end else begin
            if (close) begin
                if (state_q == StIdle) begin
                    red_ac_d = max_q[0] - min_q[0];
                    red_dc_d = sum_q[0][SW-1:WIN_LOG2];
                    ir_ac_d  = max_q[1] - min_q[1];
                    ir_dc_d  = sum_q[1][SW-1:WIN_LOG2];
                end else begin
                    overrun_d = 1'b1;
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (close) state_d = StMult;
                end
                StMult: begin
                    num_d  = {prod_n, {FRAC{1'b0}}};
                    den_d  = prod_d;
                    rem_d  = '0;
                    step_d = '0;
                    if (prod_d == '0) begin
                        state_d = StDone;
                        ratio_d = '1;
                        err_d   = 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        state_d = StDiv;
                    end
                end
                StDiv: begin
                    num_d  = num_next;
                    rem_d  = q_bit ? rem_diff : rem_sh[15:0];
                    step_d = step_q + 1'b1;
                    if (step_q == LAST) begin
                        state_d = StDone;
                        err_d   = 1'b0;
                        valid_d = 1'b1;
                        ratio_d = (|num_next[NW-1:RATIO_W]) ? '1 : num_next[RATIO_W-1:0];
                    end
                end
                StDone: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_red_q <= 1'b0;
            led_ir_q  <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                cnt_q[c] <= '0;
                max_q[c] <= '0;
                min_q[c] <= '0;
                sum_q[c] <= '0;
            end
            state_q   <= StIdle;
            num_q     <= '0;
            den_q     <= '0;
            rem_q     <= '0;
            step_q    <= '0;
            red_ac_q  <= '0;
            red_dc_q  <= '0;
            ir_ac_q   <= '0;
            ir_dc_q   <= '0;
            ratio_q   <= '0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            led_red_q <= bus.led_red;
            led_ir_q  <= bus.led_ir;
            for (int c = 0; c < 2; c++) begin
                cnt_q[c] <= cnt_d[c];
                max_q[c] <= max_d[c];
                min_q[c] <= min_d[c];
                sum_q[c] <= sum_d[c];
            end
            state_q   <= state_d;
            num_q     <= num_d;
            den_q     <= den_d;
            rem_q     <= rem_d;
            step_q    <= step_d;
            red_ac_q  <= red_ac_d;
            red_dc_q  <= red_dc_d;
            ir_ac_q   <= ir_ac_d;
            ir_dc_q   <= ir_dc_d;
            ratio_q   <= ratio_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.red_ac      = red_ac_q;
    assign bus.red_dc      = red_dc_q;
    assign bus.ir_ac       = ir_ac_q;
    assign bus.ir_dc       = ir_dc_q;
    assign bus.ratio       = ratio_q;
    assign bus.ratio_valid = valid_q;
    assign bus.ratio_err   = err_q;
    assign bus.overrun     = overrun_q;
    assign bus.busy        = (state_q != StIdle);
endmodule

// File: tb/tb_ppg_ratio_engine.sv
// tb_ppg_ratio_engine: drives LED/ADC traffic into ppg_ratio_engine, predicts each window result
// from sample lists with plain arithmetic, and checks every ratio_valid against a queue.
module tb_ppg_ratio_engine;
    localparam int WIN_LOG2 = 2;
    localparam int FRAC     = 7;
    localparam int RATIO_W  = 10;
    localparam int FULL     = 1 << WIN_LOG2;
    localparam int RMAX     = (1 << RATIO_W) - 1;
    localparam int LAT_DIV  = 18 + FRAC;
    localparam int LAT_ERR  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ppg_ratio_if #(.RATIO_W(RATIO_W)) bus ();

    ppg_ratio_engine #(.WIN_LOG2(WIN_LOG2), .FRAC(FRAC), .RATIO_W(RATIO_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int e;
        int ratio;
        int err;
        int rac;
        int rdc;
        int iac;
        int idc;
    } exp_t;

    exp_t exp_q[$];
    int   red_s[$];
    int   ir_s[$];
    bit   prev_r, prev_i;
    int   last_valid_e;
    bit   m_ov;
    int   snap[4];
    bit   cur_lr, cur_li;

    function automatic void stats(input int s[$], output int ac, output int dc);
        int mx = s[0];
        int mn = s[0];
        int sm = 0;
        foreach (s[k]) begin
            if (s[k] > mx) mx = s[k];
            if (s[k] < mn) mn = s[k];
            sm += s[k];
        end
        ac = mx - mn;
        dc = sm / FULL;
    endfunction

    task automatic model_reset();
        red_s.delete();
        ir_s.delete();
        exp_q.delete();
        prev_r = 0;
        prev_i = 0;
        last_valid_e = 0;
        m_ov = 0;
        snap = '{0, 0, 0, 0};
    endtask

    // Cycle e is the cycle that ends at posedge number e.
    task automatic model_cycle(input bit te, input bit lr, input bit li, input int r,
                               input int i, input int e);
        bit fr, fi;
        exp_t x;
        int n, d;
        fr = te && prev_r && !lr;
        fi = te && prev_i && !li;
        prev_r = lr;
        prev_i = li;
        if (!te) begin
            red_s.delete();
            ir_s.delete();
            m_ov = 0;
            while (exp_q.size() > 0 && exp_q[exp_q.size()-1].e > e) void'(exp_q.pop_back());
            if (last_valid_e > e) last_valid_e = e;
            return;
        end
        if (red_s.size() == FULL && ir_s.size() == FULL) begin
            if (e > last_valid_e) begin
                stats(red_s, x.rac, x.rdc);
                stats(ir_s, x.iac, x.idc);
                n = x.rac * x.idc * (1 << FRAC);
                d = x.iac * x.rdc;
                if (d == 0) begin
                    x.ratio = RMAX;
                    x.err = 1;
                    x.e = e + LAT_ERR;
                end else begin
                    x.ratio = (n / d > RMAX) ? RMAX : n / d;
                    x.err = 0;
                    x.e = e + LAT_DIV;
                end
                exp_q.push_back(x);
                last_valid_e = x.e;
                snap = '{x.rac, x.rdc, x.iac, x.idc};
            end else begin
                m_ov = 1;
            end
            red_s.delete();
            ir_s.delete();
        end
        if (fr && red_s.size() < FULL) red_s.push_back(r);
        if (fi && ir_s.size() < FULL) ir_s.push_back(i);
    endtask

    task automatic cyc(input bit te, input bit lr, input bit li, input int r, input int i);
        @(posedge clk);
        #1;
        bus.track_en = te;
        bus.led_red = lr;
        bus.led_ir = li;
        bus.red_adc = 8'(r);
        bus.ir_adc = 8'(i);
        cur_lr = lr;
        cur_li = li;
        model_cycle(te, lr, li, r, i, edge_cnt + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1, cur_lr, cur_li, 0, 0);
    endtask

    task automatic clear();
        cyc(0, 0, 0, 0, 0);
        idle(2);
    endtask

    task automatic sample_pair(input int r, input int i);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, r, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, i);
    endtask

    task automatic window(input int r0, r1, r2, r3, input int i0, i1, i2, i3);
        sample_pair(r0, i0);
        sample_pair(r1, i1);
        sample_pair(r2, i2);
        sample_pair(r3, i3);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ratio"}, int'(bus.ratio), 0);
        chk({tag, "_valid"}, int'(bus.ratio_valid), 0);
        chk({tag, "_err"}, int'(bus.ratio_err), 0);
        chk({tag, "_overrun"}, int'(bus.overrun), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_red_ac"}, int'(bus.red_ac), 0);
        chk({tag, "_red_dc"}, int'(bus.red_dc), 0);
        chk({tag, "_ir_ac"}, int'(bus.ir_ac), 0);
        chk({tag, "_ir_dc"}, int'(bus.ir_dc), 0);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_red_ac"}, int'(bus.red_ac), snap[0]);
        chk({tag, "_red_dc"}, int'(bus.red_dc), snap[1]);
        chk({tag, "_ir_ac"}, int'(bus.ir_ac), snap[2]);
        chk({tag, "_ir_dc"}, int'(bus.ir_dc), snap[3]);
        chk({tag, "_overrun"}, int'(bus.overrun), int'(m_ov));
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_pending_valids"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        bus.led_red = 1'b0;
        bus.led_ir = 1'b0;
        cur_lr = 0;
        cur_li = 0;
        #1;
        check_zero("midrst");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every ratio_valid must match the oldest predicted result, in the predicted cycle.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (!rst && bus.ratio_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got ratio_valid=1 with ratio %0d, required no strobe (t=%0t)",
                             bus.ratio, $time);
                end else begin
                    x = exp_q.pop_front();
                    chk("valid_cycle", edge_cnt + 1, x.e);
                    chk("ratio", int'(bus.ratio), x.ratio);
                    chk("ratio_err", int'(bus.ratio_err), x.err);
                    chk("red_ac", int'(bus.red_ac), x.rac);
                    chk("red_dc", int'(bus.red_dc), x.rdc);
                    chk("ir_ac", int'(bus.ir_ac), x.iac);
                    chk("ir_dc", int'(bus.ir_dc), x.idc);
                end
            end
        end
    end

    initial begin
        bus.track_en = 1'b1;
        bus.led_red = 1'b0;
        bus.led_ir = 1'b0;
        bus.red_adc = '0;
        bus.ir_adc = '0;
        cur_lr = 0;
        cur_li = 0;
        model_reset();
        #1 rst = 1'b1;
        #2;
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Nominal window.
        window(100, 140, 120, 100, 50, 90, 70, 70);
        idle(40);
        check_state("nominal");
        chk("nominal_ratio_const", int'(bus.ratio), 77);
        chk("nominal_red_dc_const", int'(bus.red_dc), 115);

        // Flat IR: zero denominator.
        clear();
        window(100, 140, 120, 100, 80, 80, 80, 80);
        idle(40);
        check_state("flat_ir");
        chk("flat_ir_ratio_const", int'(bus.ratio), RMAX);
        chk("flat_ir_err_const", int'(bus.ratio_err), 1);

        // Saturating quotient.
        clear();
        window(0, 255, 0, 255, 100, 101, 100, 101);
        idle(40);
        check_state("saturate");
        chk("saturate_ratio_const", int'(bus.ratio), RMAX);
        chk("saturate_err_const", int'(bus.ratio_err), 0);

        // Second window closes while the divider runs.
        clear();
        for (int k = 0; k < 8; k++) begin
            cyc(1, 1, 1, 0, 0);
            cyc(1, 0, 0, 10 + 20 * (k % 4) + k, 200 - 7 * (k % 4));
        end
        idle(40);
        check_state("overrun");
        chk("overrun_set", int'(bus.overrun), 1);
        cyc(0, 0, 0, 0, 0);
        idle(2);
        chk("overrun_cleared", int'(bus.overrun), 0);

        // Simultaneous falls and a surplus RED sample.
        clear();
        cyc(1, 1, 1, 0, 0);
        cyc(1, 0, 0, 100, 50);
        cyc(1, 1, 1, 0, 0);
        cyc(1, 0, 0, 140, 90);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 120, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 100, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 250, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 70);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 70);
        idle(40);
        check_state("surplus");
        chk("surplus_red_ac_const", int'(bus.red_ac), 40);
        chk("surplus_ratio_const", int'(bus.ratio), 77);

        // Reset in the middle of a division, then a clean window.
        clear();
        window(100, 140, 120, 100, 50, 90, 70, 70);
        idle(10);
        do_reset();
        idle(30);
        window(0, 255, 0, 255, 100, 101, 100, 101);
        idle(40);
        check_state("post_reset");
        chk("post_reset_ratio_const", int'(bus.ratio), RMAX);

        // Random traffic with occasional track_en drops.
        clear();
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)));
        end
        idle(40);
        check_state("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
